// File: rtl/tff_counter_ctrl_if.sv
// Control/status bundle between a sequencer (master) and the T-FF
// counter controller (slave).
interface tff_counter_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             tc;
    logic             done;

    modport master (
        output start, stop, mode, load, load_val,
        input  t_vec, q, busy, tc, done
    );

    modport slave (
        input  start, stop, mode, load, load_val,
        output t_vec, q, busy, tc, done
    );
endinterface

// File: rtl/tff_counter_ctrl.sv
// Sequencer for a bank of T flip-flops: holds the bank state and produces
// per-bit toggle enables for binary up, binary down or Gray up counting.
module tff_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    tff_counter_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_GRAY = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    state_t           state, state_nxt;
    logic [1:0]       mode_r, mode_nxt;
    logic [WIDTH-1:0] q_r, q_nxt;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] up_t, dn_t, gray_t;
    logic [WIDTH-1:0] gray_bin, bin_inc, gray_inc;
    logic [WIDTH-1:0] lo_mask;
    logic [WIDTH-1:0] term;
    logic             tc;
    logic             busy, done;

    // Binary toggles: bit i flips when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        up_t    = '0;
        dn_t    = '0;
        lo_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lo_mask = (WIDTH'(1) << i) - WIDTH'(1);
            up_t[i] = ((q_r & lo_mask) == lo_mask);
            dn_t[i] = ((q_r & lo_mask) == '0);
        end
    end

    // Gray up: decode to binary, increment, re-encode; the diff is one-hot.
    always_comb begin
        gray_bin = '0;
        for (int i = 0; i < WIDTH; i++)
            gray_bin[i] = ^(q_r >> i);
    end
    assign bin_inc  = gray_bin + WIDTH'(1);
    assign gray_inc = bin_inc ^ (bin_inc >> 1);
    assign gray_t   = q_r ^ gray_inc;

    always_comb begin
        term = '1;
        case (mode_r)
            MODE_UP:   term = '1;
            MODE_DOWN: term = '0;
            MODE_GRAY: term = {1'b1, {(WIDTH-1){1'b0}}};
            default:   term = '1;
        endcase
    end
    assign tc = (mode_r != MODE_RSVD) && (q_r == term);

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_r;
        t         = '0;
        busy      = 1'b0;
        done      = 1'b0;
        q_nxt     = q_r;
        case (state)
            IDLE: begin
                if (bus.load)
                    q_nxt = bus.load_val;
                if (bus.start && bus.mode != MODE_RSVD) begin
                    mode_nxt  = bus.mode;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (bus.stop) begin
                    state_nxt = IDLE;
                end else if (tc) begin
                    state_nxt = DONE;
                end else begin
                    case (mode_r)
                        MODE_UP:   t = up_t;
                        MODE_DOWN: t = dn_t;
                        MODE_GRAY: t = gray_t;
                        default:   t = '0;
                    endcase
                end
                q_nxt = q_r ^ t;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mode_r <= MODE_UP;
            q_r    <= '0;
        end else begin
            state  <= state_nxt;
            mode_r <= mode_nxt;
            q_r    <= q_nxt;
        end
    end

    assign bus.t_vec = t;
    assign bus.q     = q_r;
    assign bus.busy  = busy;
    assign bus.tc    = tc;
    assign bus.done  = done;
endmodule

// File: doc/tff_counter_ctrl.md
Name: tff_counter_ctrl

Overview:
Sequencing controller for a bank of WIDTH toggle flip-flops. It holds the bank state q and computes the per-bit toggle-enable vector t_vec each cycle, so the bank counts binary-up, binary-down or Gray-up from a loaded value to a terminal value. Software or a parent FSM drives it with start, stop and load controls. It is the standard way the team builds counters out of T-FF cells.

Parameters:
WIDTH, 4, number of T-FF bits in the bank (2..16).

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin counting; sampled in IDLE only
stop  input  1  abort counting; sampled in RUN only
mode  input  2  00 binary up, 01 binary down, 10 Gray up, 11 reserved
load  input  1  load q from load_val; sampled in IDLE only
load_val  input  WIDTH  preload value for the bank
t_vec  output  WIDTH  toggle enables applied to the bank this cycle (combinational)
q  output  WIDTH  bank state (registered)
busy  output  1  high while in RUN
tc  output  1  q equals the terminal value of the latched mode (combinational)
done  output  1  one-cycle pulse on normal completion

Behaviour:
- Reset (async, rst_n=0): q=0, state=IDLE, mode_r=00; t_vec=0, busy=0, done=0. Takes effect immediately, including mid-RUN. Release is synchronous to the next rising edge.
- Bank update every edge: q <= q ^ t_vec. No other path writes q except load.
- States: IDLE, RUN, DONE.
- IDLE:
  - t_vec=0.
  - load=1: q <= load_val.
  - start=1 and mode!=11: mode_r <= mode, next state RUN.
  - start with mode=11 is ignored.
  - load and start in the same cycle: both take effect, so RUN begins with q=load_val.
- RUN:
  - busy=1; t_vec is computed from q and mode_r.
  - Up: t[0]=1, t[i]=AND(q[i-1:0]).
  - Down: t[0]=1, t[i]=AND(~q[i-1:0]).
  - Gray up: t = q XOR gray(bin(q)+1), where bin() is Gray-to-binary and the +1 is WIDTH-bit. Exactly one bit of t is set.
  - Terminal values: up = all ones; down = 0; Gray = gray(all ones) = 1 followed by WIDTH-1 zeros.
  - tc=1 in RUN: t_vec forced to 0, next state DONE.
  - stop=1: t_vec forced to 0, next state IDLE, no done pulse. stop has priority over tc.
  - start, load and mode changes are ignored.
- DONE: done=1 and t_vec=0 for exactly one cycle, then IDLE. start and load are ignored in DONE.
- tc is valid in every state, evaluated against mode_r.
- Latency:
  - start sampled at edge E gives RUN after E; first toggle at E+1.
  - From q=v0 with N steps to terminal, terminal is reached at E+N, DONE follows at E+N+1 (done high during the next cycle), IDLE at E+N+2.
  - start with q already terminal: one RUN cycle, then DONE.
- No wrap-around: counting always stops at the terminal value. Restarting from terminal completes immediately unless load is used first.

Test Plan:
- WIDTH=4, reset, mode=00, start pulse → q steps 1,2,…,15 on consecutive edges; t_vec=0011 when q=0001 and 1111 when q=0111; busy high 16 cycles; single done pulse; return to IDLE with q=15.
- load_val=1010 with load+start in the same IDLE cycle, mode=01 → q runs 1010,1001,…,0000; done after 10 decrements; t_vec at q=1000 equals 1111.
- mode=10 from q=0000 → sequence 0000,0001,0011,0010,0110,…,1000; every t_vec is one-hot; done when q=1000.
- Up count, stop asserted when q=0101 → q holds 0101; busy drops next cycle; done never pulses; load and start in the same cycle as stop are ignored.
- rst_n pulsed low mid-RUN at q=0110 → q=0, busy=0 and t_vec=0 immediately without waiting for a clock; next start counts from 0.
- mode=11 with start → remains IDLE, busy=0; load asserted during RUN or DONE → q unaffected.
